// File: rtl/reg_file_sb_pkg.sv
//------------------------------------------------------------------------------
// Module   : reg_file_pkg
// Purpose  : Shared defaults and helpers for the scoreboarded register file.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // The busy counter must hold every register busy at once (0..2**addr_w).
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_sb_if.sv
//------------------------------------------------------------------------------
// Module   : reg_file_sb_if
// Purpose  : Read, writeback, issue and scoreboard signals of the register file.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
);
  localparam int CNT_W = cnt_width(ADDR_W);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;
  logic [2**ADDR_W-1:0]     busy_vec;
  logic [CNT_W-1:0]         busy_cnt;

  // Pipeline side: drives addresses and strobes, observes data and busy state.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_vec, busy_cnt
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_vec, busy_cnt
  );

endinterface

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : reg_file_scoreboard
// Purpose  : Per-register busy bits and busy counter with flush > issue >
//            writeback priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        iss_en,
  input  wire logic [ADDR_W-1:0]           iss_addr,
  input  wire logic                        wr_en,
  input  wire logic [ADDR_W-1:0]           wr_addr,
  input  wire logic                        flush,
  output logic      [2**ADDR_W-1:0]        busy_vec,
  output logic      [cnt_width(ADDR_W)-1:0] busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = cnt_width(ADDR_W);

  logic             iss_ok;
  logic             set_occ;
  logic             clr_occ;
  logic [DEPTH-1:0] busy_nxt;

  // Issue to a hard-wired zero register never produces a pending result.
  assign iss_ok  = iss_en && !(ZERO_REG != 0 && iss_addr == '0);
  // A set only counts if the bit was clear; a clear only counts if the bit was
  // set and no same-register issue keeps it alive.
  assign set_occ = iss_ok && !busy_vec[iss_addr];
  assign clr_occ = wr_en && busy_vec[wr_addr] && !(iss_ok && iss_addr == wr_addr);

  // Writeback clears first, then issue sets, so the new producer wins a tie.
  always_comb begin
    busy_nxt = busy_vec;
    if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
    if (iss_ok) busy_nxt[iss_addr] = 1'b1;
  end

  // Busy state and population count; flush squashes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busy_nxt;
      busy_cnt <= busy_cnt + {{(CNT_W-1){1'b0}}, set_occ} - {{(CNT_W-1){1'b0}}, clr_occ};
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
//------------------------------------------------------------------------------
// Module   : reg_file_sb
// Purpose  : Multi-read-port register file with write-first bypass, optional
//            zero register and busy scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input wire logic     clk,
  input wire logic     rst_n,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = cnt_width(ADDR_W);

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         busy_vec;
  logic [CNT_W-1:0]         busy_cnt;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_ok;

  assign wr_ok = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);

  // Storage array; writes to a hard-wired zero register are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read muxes with write-first forwarding; a same-cycle writeback also
  // reports the register as no longer busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] addr;
      logic              hit;
      addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
      hit  = bus.wr_en && (bus.wr_addr == addr);
      if (ZERO_REG != 0 && addr == '0)
        rd_data[k*DATA_W +: DATA_W] = '0;
      else if (BYPASS != 0 && hit)
        rd_data[k*DATA_W +: DATA_W] = bus.wr_data;
      else
        rd_data[k*DATA_W +: DATA_W] = regs[addr];
      rd_busy[k] = busy_vec[addr] && !hit;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .flush    (bus.flush),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  assign bus.rd_data  = rd_data;
  assign bus.rd_busy  = rd_busy;
  assign bus.busy_vec = busy_vec;
  assign bus.busy_cnt = busy_cnt;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_file_sb
// Purpose  : Self-checking bench: default configuration (bypass, zero reg) and
//            a 16-bit / 8-entry / 4-port configuration without bypass or zero
//            register driven against a reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int BD = 16;
  localparam int BA = 3;
  localparam int BN = 4;
  localparam int BDEPTH = 2**BA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
  reg_file_sb_if #(.DATA_W(BD), .ADDR_W(BA), .NUM_RD(BN)) ifb ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  reg_file_sb #(.DATA_W(BD), .ADDR_W(BA), .NUM_RD(BN), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // Reference state for dut_b.
  logic [BD-1:0]     m_regs [BDEPTH];
  logic [BDEPTH-1:0] m_busy;

  task automatic push_exp(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.rd_addr = '0; ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.iss_en = 1'b0; ifa.iss_addr = '0; ifa.flush = 1'b0;
    ifb.rd_addr = '0; ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.iss_en = 1'b0; ifb.iss_addr = '0; ifb.flush = 1'b0;

    // Reset state, no clock edge yet.
    #1;
    ifa.rd_addr = {5'd6, 5'd5};
    #1;
    push_exp(64'h0); check("reset_rd0", 64'(ifa.rd_data[31:0]));
    push_exp(64'h0); check("reset_busy_vec", 64'(ifa.busy_vec));
    push_exp(64'h0); check("reset_busy_cnt", 64'(ifa.busy_cnt));
    #11 rst_n = 1'b1;
    tick();

    // Write-first bypass on port 0, port 1 reads an untouched register.
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 32'hDEADBEEF;
    ifa.rd_addr = {5'd6, 5'd5};
    #2;
    push_exp(64'hDEADBEEF); check("bypass_rd0", 64'(ifa.rd_data[31:0]));
    push_exp(64'h0);        check("bypass_rd1", 64'(ifa.rd_data[63:32]));
    tick();
    ifa.wr_en = 1'b0;
    #2;
    push_exp(64'hDEADBEEF); check("stored_rd0", 64'(ifa.rd_data[31:0]));
    tick();

    // Zero register: write and issue are both ignored.
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd0; ifa.wr_data = 32'h1234;
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd0;
    ifa.rd_addr = {5'd5, 5'd0};
    #2;
    push_exp(64'h0); check("zero_rd_same_cycle", 64'(ifa.rd_data[31:0]));
    tick();
    ifa.wr_en = 1'b0; ifa.iss_en = 1'b0;
    #2;
    push_exp(64'h0); check("zero_rd_after", 64'(ifa.rd_data[31:0]));
    push_exp(64'h0); check("zero_busy_vec", 64'(ifa.busy_vec));
    push_exp(64'h0); check("zero_busy_cnt", 64'(ifa.busy_cnt));

    // Issue register 3.
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd3; ifa.rd_addr = {5'd3, 5'd3};
    tick();
    ifa.iss_en = 1'b0;
    #2;
    push_exp(64'h8); check("iss3_busy_vec", 64'(ifa.busy_vec));
    push_exp(64'h1); check("iss3_busy_cnt", 64'(ifa.busy_cnt));
    push_exp(64'h1); check("iss3_rd_busy1", 64'(ifa.rd_busy[1]));

    // Issue and writeback to register 3 together: new producer wins.
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd3;
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'h33;
    #2;
    push_exp(64'h0); check("iss_wr3_rd_busy_same", 64'(ifa.rd_busy[1]));
    tick();
    ifa.iss_en = 1'b0; ifa.wr_en = 1'b0;
    #2;
    push_exp(64'h8); check("iss_wr3_busy_vec", 64'(ifa.busy_vec));
    push_exp(64'h1); check("iss_wr3_busy_cnt", 64'(ifa.busy_cnt));

    // Writeback of register 3 alone.
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'h44;
    #2;
    push_exp(64'h0);  check("wr3_rd_busy_same", 64'(ifa.rd_busy[1]));
    push_exp(64'h44); check("wr3_rd_data_bypass", 64'(ifa.rd_data[63:32]));
    tick();
    ifa.wr_en = 1'b0;
    #2;
    push_exp(64'h0); check("wr3_busy_vec", 64'(ifa.busy_vec));
    push_exp(64'h0); check("wr3_busy_cnt", 64'(ifa.busy_cnt));

    // Flush beats a same-cycle issue.
    ifa.iss_en = 1'b1;
    ifa.iss_addr = 5'd1; tick();
    ifa.iss_addr = 5'd2; tick();
    ifa.iss_addr = 5'd7; tick();
    ifa.iss_en = 1'b0;
    #2;
    push_exp(64'h86); check("pre_flush_busy_vec", 64'(ifa.busy_vec));
    push_exp(64'h3);  check("pre_flush_busy_cnt", 64'(ifa.busy_cnt));
    ifa.flush = 1'b1; ifa.iss_en = 1'b1; ifa.iss_addr = 5'd9;
    tick();
    ifa.flush = 1'b0; ifa.iss_en = 1'b0;
    #2;
    push_exp(64'h0); check("flush_busy_vec", 64'(ifa.busy_vec));
    push_exp(64'h0); check("flush_busy_cnt", 64'(ifa.busy_cnt));

    // Issue and writeback to different registers both apply.
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd10; tick();
    ifa.iss_addr = 5'd11;
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd10; ifa.wr_data = 32'hA5A5;
    tick();
    ifa.iss_en = 1'b0; ifa.wr_en = 1'b0;
    ifa.rd_addr = {5'd11, 5'd5};
    #2;
    push_exp(64'h800); check("split_busy_vec", 64'(ifa.busy_vec));
    push_exp(64'h1);   check("split_busy_cnt", 64'(ifa.busy_cnt));
    push_exp(64'h1);   check("split_rd_busy1", 64'(ifa.rd_busy[1]));

    // Asynchronous reset mid-run, observed without a clock edge.
    rst_n = 1'b0;
    #1;
    push_exp(64'h0); check("midreset_rd0", 64'(ifa.rd_data[31:0]));
    push_exp(64'h0); check("midreset_rd1", 64'(ifa.rd_data[63:32]));
    push_exp(64'h0); check("midreset_rd_busy", 64'(ifa.rd_busy));
    push_exp(64'h0); check("midreset_busy_vec", 64'(ifa.busy_vec));
    push_exp(64'h0); check("midreset_busy_cnt", 64'(ifa.busy_cnt));
    #1 rst_n = 1'b1;
    tick();

    // No-bypass configuration: old value during the write, new value after.
    ifb.wr_en = 1'b1; ifb.wr_addr = 3'd5; ifb.wr_data = 16'h1111;
    tick();
    ifb.wr_data = 16'hBEEF;
    ifb.rd_addr = {3'd0, 3'd0, 3'd0, 3'd5};
    #2;
    push_exp(64'h1111); check("nobypass_old", 64'(ifb.rd_data[15:0]));
    tick();
    ifb.wr_en = 1'b0;
    #2;
    push_exp(64'hBEEF); check("nobypass_new", 64'(ifb.rd_data[15:0]));
    tick();

    // Random sweep against the reference model.
    for (int i = 0; i < BDEPTH; i++) m_regs[i] = '0;
    m_regs[5] = 16'hBEEF;
    m_busy = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [BA-1:0] ra [BN];
      logic [BDEPTH-1:0] nb;
      ifb.wr_en    = 1'($urandom_range(0, 1));
      ifb.wr_addr  = BA'($urandom_range(0, BDEPTH-1));
      ifb.wr_data  = BD'($urandom);
      ifb.iss_en   = 1'($urandom_range(0, 1));
      ifb.iss_addr = BA'($urandom_range(0, BDEPTH-1));
      ifb.flush    = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < BN; k++) begin
        ra[k] = BA'($urandom_range(0, BDEPTH-1));
        ifb.rd_addr[k*BA +: BA] = ra[k];
      end
      #2;
      for (int k = 0; k < BN; k++) begin
        push_exp(64'(m_regs[ra[k]]));
        check("rand_rd_data", 64'(ifb.rd_data[k*BD +: BD]));
        push_exp(64'(m_busy[ra[k]] && !(ifb.wr_en && ifb.wr_addr == ra[k])));
        check("rand_rd_busy", 64'(ifb.rd_busy[k]));
      end
      push_exp(64'(m_busy));           check("rand_busy_vec", 64'(ifb.busy_vec));
      push_exp(64'($countones(m_busy))); check("rand_busy_cnt", 64'(ifb.busy_cnt));
      // Model next state.
      if (ifb.wr_en) m_regs[ifb.wr_addr] = ifb.wr_data;
      nb = m_busy;
      if (ifb.flush) begin
        nb = '0;
      end else begin
        if (ifb.wr_en)  nb[ifb.wr_addr]  = 1'b0;
        if (ifb.iss_en) nb[ifb.iss_addr] = 1'b1;
      end
      m_busy = nb;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port register file with write-first bypass, optional hard-wired zero register, and a per-register busy scoreboard. It replaces the fixed 32×32, two-read, one-write register file in the pipelined datapath. Decode reads operands and marks destinations busy at issue. Writeback writes results and clears busy. Hazard logic consumes the per-port busy flags.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; clears all registers and busy bits
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy  out  NUM_RD  scoreboard busy flag of each addressed register
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  issue strobe; marks iss_addr busy
- iss_addr  in  ADDR_W  destination of issuing instruction
- flush  in  1  clears every busy bit (pipeline squash)
- busy_vec  out  2**ADDR_W  registered busy bits, bit i = register i
- busy_cnt  out  ADDR_W+1  number of set busy bits

## Operation
- Storage: 2**ADDR_W × DATA_W flops. Scoreboard: 2**ADDR_W busy flops plus busy_cnt counter.
- Write: on posedge clk, when wr_en is high, reg[wr_addr] takes wr_data. Suppressed when ZERO_REG=1 and wr_addr=0.
- Read: combinational per port, rd_data[k] = reg[rd_addr[k]].
  - ZERO_REG=1 and rd_addr[k]=0: returns 0.
  - BYPASS=1 and wr_en and wr_addr=rd_addr[k] (non-zero, or ZERO_REG=0): returns wr_data (write-first).
- Busy update at posedge, evaluated in priority order:
  - flush: every bit goes to 0, overriding issue and writeback.
  - Else for a bit b: issue to b sets it; otherwise writeback to b clears it.
  - Issue and writeback to the same register in the same cycle leave busy=1, because the new producer wins.
  - Issue and writeback to different registers both take effect.
- Register 0 with ZERO_REG=1: issue is ignored, and the bit stays 0.
- rd_busy[k]: busy_vec[rd_addr[k]], forced to 0 when a same-cycle wr_en targets that address. Issue is not forwarded.
- busy_cnt: registered. Next value = current + (set occurred) − (clear occurred). On flush it goes to 0. It always equals popcount(busy_vec).
- Writing a register that is not busy is legal: data updates, and busy stays 0.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, busy_vec 0, busy_cnt 0. rd_data then reads 0 for every address. rd_busy is 0.
- Deasserting reset mid-cycle takes effect at the next posedge. Pending issue and writeback state is lost.
- Read latency 0: combinational from rd_addr, wr_* and the state.
- Write latency 1: without bypass, data is visible to reads in the cycle after the wr_en edge.
- Issue latency 1: busy_vec and rd_busy reflect an issue from the following cycle.
- Clear via writeback is visible on rd_busy in the same cycle and on busy_vec in the next cycle.
- Flush is visible on busy_vec and busy_cnt in the next cycle.

## Structure
- Package reg_file_pkg: default DATA_W and ADDR_W localparams, and a function that computes the popcount width.
- Sub-module reg_file_scoreboard owns busy_vec, busy_cnt and the issue/writeback/flush priority logic.
- The top level owns the storage array, the read muxes and the bypass logic.

## Test plan
- Reset then read: assert rst_n=0 mid-run after writes. All ports must read 0, busy_vec=0 and busy_cnt=0 immediately, with no clock required.
- Write-first bypass: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr[0]=5 in the same cycle. rd_data[0]=0xDEADBEEF combinationally. With BYPASS=0 it shows the old value, and the new value the next cycle.
- Zero register: write 0x1234 to register 0 and issue to register 0. Register 0 still reads 0, busy_vec[0]=0 and busy_cnt unchanged.
- Scoreboard sequence:
  - Issue register 3: busy_vec[3]=1 and busy_cnt=1 next cycle.
  - Same-cycle issue of register 3 and writeback of register 3: busy stays 1 and busy_cnt stays 1.
  - Writeback of register 3 alone: rd_busy goes 0 that cycle, and busy_cnt=0 next cycle.
- Flush priority: registers 1, 2 and 7 busy, then flush with iss_en to register 9 in the same cycle. Next cycle busy_vec=0 and busy_cnt=0.
- Parametric sweep: NUM_RD=4, ADDR_W=3, DATA_W=16. Random issue, writeback and reads checked against a reference model for 10k cycles. Check busy_cnt = popcount(busy_vec) every cycle.
